// File: rtl/prio_encoder_queue.sv
// ============================================================================
// prio_encoder_queue : pending-request latch with a registered valid/ready
//                      priority (fixed or round-robin) index output.
// Revision 1.0
// ============================================================================
`default_nettype none

module prio_encoder_queue #(
    parameter int N     = 8,
    parameter int IDX_W = $clog2(N),
    parameter bit RR    = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [N-1:0]     req,
    input  logic [N-1:0]     mask,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [IDX_W-1:0] out_idx,
    output logic [N-1:0]     pending,
    output logic             any_pending
);

    logic [N-1:0]     pending_q, pending_d;
    logic             out_valid_q, out_valid_d;
    logic [IDX_W-1:0] out_idx_q, out_idx_d;
    logic [IDX_W-1:0] last_idx_q, last_idx_d;

    logic             w_hs;
    logic [N-1:0]     w_clr;
    logic [N-1:0]     w_elig;
    logic             w_load;
    logic             w_found_lo;
    logic [IDX_W-1:0] w_sel_lo;
    logic [IDX_W-1:0] w_sel_hi;
    logic [IDX_W-1:0] w_sel;

    assign w_hs   = out_valid_q & out_ready;
    assign w_clr  = w_hs ? (N'(1) << out_idx_q) : '0;
    assign w_elig = pending_q & mask & ~w_clr;

    // Round-robin order last-1 .. 0, then N-1 .. last: take the highest bit
    // below last_idx if any, else the highest bit at or above it. In fixed
    // mode last_idx stays 0, which reduces this to plain highest-index-wins.
    always_comb begin
        w_found_lo = 1'b0;
        w_sel_lo   = '0;
        w_sel_hi   = '0;
        for (int i = 0; i < N; i++) begin
            if (w_elig[i]) begin
                if (IDX_W'(i) < last_idx_q) begin
                    w_found_lo = 1'b1;
                    w_sel_lo   = IDX_W'(i);
                end else begin
                    w_sel_hi   = IDX_W'(i);
                end
            end
        end
        w_sel = w_found_lo ? w_sel_lo : w_sel_hi;
    end

    assign w_load = en & (~out_valid_q | w_hs) & (|w_elig);

    always_comb begin
        pending_d   = (pending_q & ~w_clr) | req;
        out_valid_d = out_valid_q;
        out_idx_d   = out_idx_q;
        last_idx_d  = last_idx_q;
        if (w_load) begin
            out_valid_d = 1'b1;
            out_idx_d   = w_sel;
            if (RR) begin
                last_idx_d = w_sel;
            end
        end else if (w_hs) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pending_q   <= '0;
            out_valid_q <= 1'b0;
            out_idx_q   <= '0;
            last_idx_q  <= '0;
        end else begin
            pending_q   <= pending_d;
            out_valid_q <= out_valid_d;
            out_idx_q   <= out_idx_d;
            last_idx_q  <= last_idx_d;
        end
    end

    assign out_valid   = out_valid_q;
    assign out_idx     = out_idx_q;
    assign pending     = pending_q;
    assign any_pending = |pending_q;

endmodule

`default_nettype wire

// File: tb/tb_prio_encoder_queue.sv
// ============================================================================
// tb_prio_encoder_queue : directed and randomized checks of both selection
//                         modes against a queue-level reference model.
// Revision 1.0
// ============================================================================
`default_nettype none

module tb_prio_encoder_queue;

    localparam int N  = 8;
    localparam int IW = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic          en;
    logic [N-1:0]  req;
    logic [N-1:0]  mask;
    logic          out_ready;

    logic          valid_f, valid_r;
    logic [IW-1:0] idx_f, idx_r;
    logic [N-1:0]  pend_f, pend_r;
    logic          any_f, any_r;

    int n_cmp = 0;
    int n_err = 0;

    // Reference state: index 0 = fixed mode, 1 = round-robin mode
    logic [N-1:0]  m_pend  [2];
    logic          m_valid [2];
    int            m_idx   [2];
    int            m_last  [2];

    prio_encoder_queue #(.N(N), .RR(1'b0)) dut_fixed (
        .clk(clk), .rst(rst), .en(en), .req(req), .mask(mask),
        .out_valid(valid_f), .out_ready(out_ready), .out_idx(idx_f),
        .pending(pend_f), .any_pending(any_f)
    );

    prio_encoder_queue #(.N(N), .RR(1'b1)) dut_rr (
        .clk(clk), .rst(rst), .en(en), .req(req), .mask(mask),
        .out_valid(valid_r), .out_ready(out_ready), .out_idx(idx_r),
        .pending(pend_r), .any_pending(any_r)
    );

    always #5 clk = ~clk;

    // Walk the search order last-1, last-2, ... (mod N) and take the first hit.
    function automatic int pick(logic [N-1:0] e, int last);
        for (int k = 1; k <= N; k++) begin
            int p;
            p = (last - k + N) % N;
            if (e[p]) return p;
        end
        return 0;
    endfunction

    task automatic model_eval();
        for (int m = 0; m < 2; m++) begin
            logic          hs;
            logic [N-1:0]  clr;
            logic [N-1:0]  elig;
            hs   = m_valid[m] & out_ready;
            clr  = hs ? (N'(1) << m_idx[m]) : '0;
            elig = m_pend[m] & mask & ~clr;
            if (rst) begin
                m_pend[m] = '0; m_valid[m] = 1'b0; m_idx[m] = 0; m_last[m] = 0;
            end else begin
                m_pend[m] = (m_pend[m] & ~clr) | req;
                if (en && (!m_valid[m] || hs) && elig != 0) begin
                    m_idx[m]   = pick(elig, m_last[m]);
                    m_valid[m] = 1'b1;
                    if (m == 1) m_last[m] = m_idx[m];
                end else if (hs) begin
                    m_valid[m] = 1'b0;
                end
            end
        end
    endtask

    task automatic step();
        model_eval();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; req = '0; en = 1'b1; mask = '1; out_ready = 1'b0;
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; req = '1; en = 1'b1; mask = '1; out_ready = 1'b1;
        repeat (2) begin
            step();
            n_cmp++;
            if (pend_f !== 8'h00 || valid_f !== 1'b0 || idx_f !== 3'd0 || any_f !== 1'b0 ||
                pend_r !== 8'h00 || valid_r !== 1'b0 || idx_r !== 3'd0 || any_r !== 1'b0) begin
                n_err++;
                $display("FAIL reset_hold got f:%h/%b/%0d/%b r:%h/%b/%0d/%b exp 00/0/0/0",
                         pend_f, valid_f, idx_f, any_f, pend_r, valid_r, idx_r, any_r);
            end
        end
        rst = 1'b0; req = '0;
        repeat (3) step();
        n_cmp++;
        if (valid_f !== 1'b0 || pend_f !== 8'h00 || valid_r !== 1'b0 || pend_r !== 8'h00) begin
            n_err++;
            $display("FAIL reset_after got valid %b/%b pend %h/%h exp 0/0 00/00",
                     valid_f, valid_r, pend_f, pend_r);
        end
    endtask

    task automatic test_fixed();
        do_reset();
        out_ready = 1'b1; req = 8'h28;
        step();
        req = '0;
        n_cmp++;
        if (pend_f !== 8'h28 || valid_f !== 1'b0) begin
            n_err++;
            $display("FAIL fixed_t1 got pend %h valid %b exp 28 0", pend_f, valid_f);
        end
        step();
        n_cmp++;
        if (valid_f !== 1'b1 || idx_f !== 3'd5 || valid_r !== 1'b1 || idx_r !== 3'd5) begin
            n_err++;
            $display("FAIL fixed_t2 got %b/%0d rr %b/%0d exp 1/5", valid_f, idx_f, valid_r, idx_r);
        end
        step();
        n_cmp++;
        if (valid_f !== 1'b1 || idx_f !== 3'd3 || valid_r !== 1'b1 || idx_r !== 3'd3) begin
            n_err++;
            $display("FAIL fixed_t3 got %b/%0d rr %b/%0d exp 1/3", valid_f, idx_f, valid_r, idx_r);
        end
        step();
        n_cmp++;
        if (valid_f !== 1'b0 || pend_f !== 8'h00 || any_f !== 1'b0) begin
            n_err++;
            $display("FAIL fixed_t4 got valid %b pend %h any %b exp 0 00 0", valid_f, pend_f, any_f);
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        out_ready = 1'b0; req = 8'h81;
        step();
        req = '0;
        step();
        for (int c = 0; c < 4; c++) begin
            n_cmp++;
            if (valid_f !== 1'b1 || idx_f !== 3'd7 || valid_r !== 1'b1 || idx_r !== 3'd7) begin
                n_err++;
                $display("FAIL bp_hold c%0d got %b/%0d rr %b/%0d exp 1/7", c, valid_f, idx_f, valid_r, idx_r);
            end
            step();
        end
        out_ready = 1'b1;
        step();
        n_cmp++;
        if (valid_f !== 1'b1 || idx_f !== 3'd0 || valid_r !== 1'b1 || idx_r !== 3'd0) begin
            n_err++;
            $display("FAIL bp_next got %b/%0d rr %b/%0d exp 1/0", valid_f, idx_f, valid_r, idx_r);
        end
        step();
        n_cmp++;
        if (valid_f !== 1'b0 || valid_r !== 1'b0) begin
            n_err++;
            $display("FAIL bp_drain got valid %b/%b exp 0/0", valid_f, valid_r);
        end
    endtask

    task automatic test_rerequest();
        do_reset();
        out_ready = 1'b0; req = 8'h84;
        step();
        req = '0;
        step();
        // Serve 7 while re-requesting it, with loads held off for that cycle
        out_ready = 1'b1; en = 1'b0; req = 8'h80;
        step();
        req = '0; en = 1'b1;
        n_cmp++;
        if (pend_f !== 8'h84 || pend_r !== 8'h84 || valid_f !== 1'b0 || valid_r !== 1'b0) begin
            n_err++;
            $display("FAIL rereq_pend got %h/%h valid %b/%b exp 84/84 0/0", pend_f, pend_r, valid_f, valid_r);
        end
        step();
        n_cmp++;
        if (idx_f !== 3'd7 || idx_r !== 3'd2 || valid_f !== 1'b1 || valid_r !== 1'b1) begin
            n_err++;
            $display("FAIL rereq_g1 got f %0d r %0d exp f 7 r 2", idx_f, idx_r);
        end
        step();
        n_cmp++;
        if (idx_f !== 3'd2 || idx_r !== 3'd7 || valid_f !== 1'b1 || valid_r !== 1'b1) begin
            n_err++;
            $display("FAIL rereq_g2 got f %0d r %0d exp f 2 r 7", idx_f, idx_r);
        end
        step();
    endtask

    task automatic test_mask_en();
        do_reset();
        out_ready = 1'b1; mask = 8'h04; req = 8'h0C;
        step();
        req = '0;
        step();
        n_cmp++;
        if (valid_f !== 1'b1 || idx_f !== 3'd2 || valid_r !== 1'b1 || idx_r !== 3'd2) begin
            n_err++;
            $display("FAIL mask_g2 got %b/%0d rr %b/%0d exp 1/2", valid_f, idx_f, valid_r, idx_r);
        end
        repeat (2) step();
        n_cmp++;
        if (valid_f !== 1'b0 || pend_f !== 8'h08 || valid_r !== 1'b0 || pend_r !== 8'h08) begin
            n_err++;
            $display("FAIL mask_park got valid %b/%b pend %h/%h exp 0/0 08/08", valid_f, valid_r, pend_f, pend_r);
        end
        mask = 8'hFF; en = 1'b0;
        repeat (2) step();
        n_cmp++;
        if (valid_f !== 1'b0 || valid_r !== 1'b0) begin
            n_err++;
            $display("FAIL en_off got valid %b/%b exp 0/0", valid_f, valid_r);
        end
        en = 1'b1;
        step();
        n_cmp++;
        if (valid_f !== 1'b1 || idx_f !== 3'd3 || valid_r !== 1'b1 || idx_r !== 3'd3) begin
            n_err++;
            $display("FAIL en_on got %b/%0d rr %b/%0d exp 1/3", valid_f, idx_f, valid_r, idx_r);
        end
        step();
    endtask

    task automatic test_reset_mid();
        do_reset();
        out_ready = 1'b0; req = 8'hF0;
        step();
        req = '0;
        repeat (2) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        n_cmp++;
        if (valid_f !== 1'b0 || idx_f !== 3'd0 || pend_f !== 8'h00 || any_f !== 1'b0 ||
            valid_r !== 1'b0 || idx_r !== 3'd0 || pend_r !== 8'h00 || any_r !== 1'b0) begin
            n_err++;
            $display("FAIL rst_mid got f %b/%0d/%h/%b r %b/%0d/%h/%b exp all 0",
                     valid_f, idx_f, pend_f, any_f, valid_r, idx_r, pend_r, any_r);
        end
        out_ready = 1'b1; req = 8'hF0;
        step();
        req = '0;
        step();
        n_cmp++;
        if (idx_r !== 3'd7 || valid_r !== 1'b1) begin
            n_err++;
            $display("FAIL rst_rr_first got %b/%0d exp 1/7", valid_r, idx_r);
        end
        step();
        n_cmp++;
        if (idx_r !== 3'd6 || valid_r !== 1'b1) begin
            n_err++;
            $display("FAIL rst_rr_second got %b/%0d exp 1/6", valid_r, idx_r);
        end
        repeat (3) step();
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            rst       = ($urandom % 64) == 0;
            req       = ($urandom % 3 == 0) ? N'($urandom) : '0;
            mask      = ($urandom % 4 == 0) ? N'($urandom) : '1;
            en        = ($urandom % 8) != 0;
            out_ready = ($urandom % 3) != 0;
            step();
            for (int m = 0; m < 2; m++) begin
                logic          v;
                logic [IW-1:0] ix;
                logic [N-1:0]  pd;
                logic          an;
                v  = m ? valid_r : valid_f;
                ix = m ? idx_r   : idx_f;
                pd = m ? pend_r  : pend_f;
                an = m ? any_r   : any_f;
                n_cmp++;
                if (v !== m_valid[m] || ix !== IW'(m_idx[m]) || pd !== m_pend[m] ||
                    an !== (m_pend[m] != 0)) begin
                    n_err++;
                    $display("FAIL rnd mode%0d cyc%0d got v%b i%0d p%h a%b exp v%b i%0d p%h a%b",
                             m, c, v, ix, pd, an, m_valid[m], m_idx[m], m_pend[m], (m_pend[m] != 0));
                end
            end
        end
    endtask

    initial begin
        for (int m = 0; m < 2; m++) begin
            m_pend[m] = '0; m_valid[m] = 1'b0; m_idx[m] = 0; m_last[m] = 0;
        end
        rst = 1'b1; en = 1'b1; req = '0; mask = '1; out_ready = 1'b0;
        test_reset();
        test_fixed();
        test_backpressure();
        test_rerequest();
        test_mask_en();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/prio_encoder_queue.md
Name: prio_encoder_queue

Overview:
- Parametrised, registered successor to the 8-to-3 combinational priority encoder.
- Latches request pulses into a pending vector and presents one index at a time on a valid/ready output.
- Selection mode is either fixed priority (highest index wins) or round-robin.
- Used as the request-to-index front end for interrupt and event sources in the design.

Parameters:
- N, 8, number of request lines (N >= 2).
- IDX_W, $clog2(N), width of the index output (derived; not overridden).
- RR, 0, 0 = fixed priority, highest index wins; 1 = round-robin, most recently granted index gets lowest priority.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- en  input  1  enables loading of new grants.
- req  input  N  request pulses, one per source; each is ORed into pending.
- mask  input  N  per-source eligibility; 1 = may be granted.
- out_valid  output  1  out_idx holds a granted index.
- out_ready  input  1  consumer accepts the grant.
- out_idx  output  IDX_W  granted source index.
- pending  output  N  registered pending vector.
- any_pending  output  1  OR of pending (combinational from register).

Behaviour:
- Reset (rst=1 at a clock edge): pending=0, out_valid=0, out_idx=0, last_idx=0 (internal round-robin pointer).
  - rst overrides all other activity, including a grant that is mid-presentation.
  - A request arriving in the reset cycle is lost.
- Handshake: hs = out_valid & out_ready.
- Pending update each cycle: pending <= (pending & ~clr) | req.
  - clr = onehot(out_idx) when hs, else 0.
  - req wins over clr: a bit served and re-requested in the same cycle stays set.
  - A request on an already-pending bit merges; requests are not counted.
- Eligible vector: elig = pending & mask & ~clr.
  - Uses the registered pending only, so a req in cycle t is not eligible before cycle t+1.
- Load condition: en & (~out_valid | hs) & (|elig).
  - On load: out_idx <= selected index, out_valid <= 1; when RR=1, last_idx <= selected index.
  - Else if hs: out_valid <= 0.
  - Otherwise out_valid and out_idx hold.
- Hold rule: while out_valid & ~out_ready, out_idx is stable.
  - The grant is never retracted, even if mask or en drop or pending changes.
- Fixed mode (RR=0): select the highest set index of elig.
- Round-robin mode (RR=1): search order is last_idx-1, last_idx-2, ... downward with wrap mod N, ending at last_idx; select the first set bit of elig.
  - After reset the order is N-1 down to 0, identical to fixed mode.
- Latency:
  - req pulse at cycle t -> pending bit set at t+1 -> out_valid/out_idx at t+2, if idle and en=1.
  - With out_ready held high, back-to-back grants come one per cycle.
- en=0: no new loads. Pending still accumulates, and a presented grant can still complete.
- mask=0 on a bit: the bit stays pending but is not granted until unmasked.
- No eligible bits: out_valid falls after hs and stays 0.
- Selection is one combinational priority search of N bits, then registered outputs. No combinational path from req to the outputs.

Test Plan:
- Reset: drive req=all-ones with rst=1 for 2 cycles, then release -> pending=0, out_valid=0, out_idx=0, any_pending=0 during reset; nothing granted afterwards.
- Fixed priority, N=8, RR=0, mask=0xFF, out_ready=1: pulse req=0x28 at cycle t:
  - pending=0x28 at t+1.
  - out_idx=5 with out_valid=1 at t+2.
  - out_idx=3 at t+3.
  - out_valid=0 and pending=0 at t+4.
- Backpressure: pending=0x81, out_ready=0 for 4 cycles -> out_idx=7 held stable and out_valid=1 throughout. Then out_ready=1 -> next cycle out_idx=0, the cycle after out_valid=0.
- Simultaneous serve and re-request:
  - RR=0: during the hs cycle for idx 7 also pulse req[7], with pending=0x84 -> pending keeps bit 7, and the next grant is 7 again, then 2.
  - RR=1, same stimulus -> next grant is 2, then 7.
- Mask and enable:
  - pending=0x0C, mask=0x04 -> grant 2 only; bit 3 stays pending with out_valid=0.
  - Set mask=0xFF with en=0 -> no grant. Raise en -> grant 3 two cycles later at most.
- Reset mid-operation: assert rst while out_valid=1, out_ready=0, pending=0xF0 -> all outputs and pending are 0 on the next cycle; last_idx returns to 0, confirmed by the next RR grant order starting at 7.
